// File: rtl/mc_control_fsm.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB with internal R-type decode,
// bounded data-memory wait and a retired-instruction counter.
//
//   state  | meaning
//   FETCH  | load IR, PC <= PC+4
//   DECODE | classify instruction, latch class, flag illegal
//   EXEC   | ALU operation; beq/jr resolve the PC here
//   MEM    | data-memory access, waits on memReady up to MEM_TIMEOUT cycles
//   WB     | register write-back; jal also redirects the PC
module mc_control_fsm #(
  parameter bit MEM_WAIT_EN = 1'b1,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic [5:0]       opCode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             memReady,
  output logic             pcWE,
  output logic             irWE,
  output logic             regWE,
  output logic             dmRE,
  output logic             dmWE,
  output logic             aluSrc,
  output logic             usExt,
  output logic [2:0]       aluCtrl,
  output logic [1:0]       regDataCtrl,
  output logic [1:0]       regDesCtrl,
  output logic [1:0]       pcSrc,
  output logic [2:0]       state,
  output logic             illegal,
  output logic             memTimeout,
  output logic [CNT_W-1:0] retired
);

  localparam int WW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    C_NONE, C_ADDU, C_SUBU, C_JR, C_ORI, C_LW, C_SW, C_BEQ, C_LUI, C_JAL, C_ILL
  } class_t;

  state_t           r_state, w_next;
  class_t           r_class, w_dec_class;
  logic [WW-1:0]    r_wait;
  logic [CNT_W-1:0] r_retired;

  logic w_pc_we, w_ir_we, w_reg_we, w_dm_re, w_dm_we;
  logic w_illegal, w_timeout, w_retire, w_mem_done;

  assign w_mem_done = (MEM_WAIT_EN == 1'b0) || memReady;

  always_comb begin
    w_dec_class = C_ILL;
    case (opCode)
      6'b000000: begin
        case (funct)
          6'b100001: w_dec_class = C_ADDU;
          6'b100011: w_dec_class = C_SUBU;
          6'b001000: w_dec_class = C_JR;
          default:   w_dec_class = C_ILL;
        endcase
      end
      6'b001101: w_dec_class = C_ORI;
      6'b100011: w_dec_class = C_LW;
      6'b101011: w_dec_class = C_SW;
      6'b000100: w_dec_class = C_BEQ;
      6'b001111: w_dec_class = C_LUI;
      6'b000011: w_dec_class = C_JAL;
      default:   w_dec_class = C_ILL;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state   <= S_FETCH;
      r_class   <= C_NONE;
      r_wait    <= '0;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE)
        r_class <= w_dec_class;
      if (r_state == S_EXEC && w_next == S_MEM)
        r_wait <= '0;
      else if (r_state == S_MEM && !memReady)
        r_wait <= r_wait + WW'(1);
      if (w_retire)
        r_retired <= r_retired + CNT_W'(1);
    end
  end

  // ALU controls are shared by EXEC and MEM so the address stays stable during the access
  always_comb begin
    aluCtrl = 3'b000;
    aluSrc  = 1'b0;
    usExt   = 1'b0;
    if (r_state == S_EXEC || r_state == S_MEM) begin
      case (r_class)
        C_SUBU:      aluCtrl = 3'b001;
        C_BEQ:       aluCtrl = 3'b001;
        C_ORI:       begin aluCtrl = 3'b011; aluSrc = 1'b1; usExt = 1'b1; end
        C_LUI:       begin aluCtrl = 3'b100; aluSrc = 1'b1; usExt = 1'b1; end
        C_LW, C_SW:  aluSrc = 1'b1;
        default:     aluCtrl = 3'b000;
      endcase
    end
  end

  always_comb begin
    w_next      = r_state;
    w_pc_we     = 1'b0;
    w_ir_we     = 1'b0;
    w_reg_we    = 1'b0;
    w_dm_re     = 1'b0;
    w_dm_we     = 1'b0;
    w_illegal   = 1'b0;
    w_timeout   = 1'b0;
    w_retire    = 1'b0;
    regDataCtrl = 2'b00;
    regDesCtrl  = 2'b00;
    pcSrc       = 2'b00;
    case (r_state)
      S_FETCH: begin
        w_ir_we = 1'b1;
        w_pc_we = 1'b1;
        w_next  = S_DECODE;
      end
      S_DECODE: begin
        case (w_dec_class)
          C_ILL: begin
            w_illegal = 1'b1;
            w_next    = S_FETCH;
          end
          C_JAL:   w_next = S_WB;
          default: w_next = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (r_class)
          C_BEQ: begin
            w_pc_we  = zero;
            pcSrc    = 2'b01;
            w_retire = 1'b1;
            w_next   = S_FETCH;
          end
          C_JR: begin
            w_pc_we  = 1'b1;
            pcSrc    = 2'b11;
            w_retire = 1'b1;
            w_next   = S_FETCH;
          end
          C_LW, C_SW: w_next = S_MEM;
          default:    w_next = S_WB;
        endcase
      end
      S_MEM: begin
        w_dm_re = (r_class == C_LW);
        w_dm_we = (r_class == C_SW);
        if (w_mem_done) begin
          w_retire = (r_class == C_SW);
          w_next   = (r_class == C_LW) ? S_WB : S_FETCH;
        end else if (r_wait == WAIT_LAST) begin
          w_timeout = 1'b1;
          w_next    = S_FETCH;
        end
      end
      S_WB: begin
        w_reg_we = 1'b1;
        w_retire = 1'b1;
        w_next   = S_FETCH;
        case (r_class)
          C_ADDU, C_SUBU: begin regDataCtrl = 2'b01; regDesCtrl = 2'b01; end
          C_ORI, C_LUI:   regDataCtrl = 2'b01;
          C_JAL: begin
            regDataCtrl = 2'b11;
            regDesCtrl  = 2'b11;
            w_pc_we     = 1'b1;
            pcSrc       = 2'b10;
          end
          default:        regDataCtrl = 2'b00;
        endcase
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Strobes are gated by reset so an in-flight access is cut off immediately
  assign pcWE       = w_pc_we   & rstN;
  assign irWE       = w_ir_we   & rstN;
  assign regWE      = w_reg_we  & rstN;
  assign dmRE       = w_dm_re   & rstN;
  assign dmWE       = w_dm_we   & rstN;
  assign illegal    = w_illegal & rstN;
  assign memTimeout = w_timeout & rstN;
  assign state      = r_state;
  assign retired    = r_retired;

endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Multi-cycle control unit for the next-generation datapath: it replaces single-cycle opcode decoding with a five-state sequencer. It sequences fetch, decode, execute, memory and write-back, and decodes R-type funct internally. It waits on a data-memory ready handshake with a bounded timeout, and counts retired instructions. It sits between the IR/ALU-flag outputs of the datapath and every write-enable and mux select in it.

## Interface
- MEM_WAIT_EN, 1, 1: MEM state waits for memReady; 0: memReady ignored, memory completes in one cycle
- MEM_TIMEOUT, 16, max cycles spent in MEM per access (≥1)
- CNT_W, 32, width of retired-instruction counter
- clk  in  1  clock, rising edge
- rstN  in  1  reset; one clock; reset is asynchronous and active-low
- opCode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU equality flag (valid in EXEC)
- memReady  in  1  data memory access complete
- pcWE, irWE, regWE, dmRE, dmWE  out  1 each  strobes
- aluSrc  out  1  0 reg2, 1 extended imm
- usExt  out  1  1 zero-extend imm
- aluCtrl  out  3  000 add, 001 sub, 010 and, 011 or, 100 imm<<16
- regDataCtrl  out  2  00 DM, 01 ALU, 11 PC (already +4)
- regDesCtrl  out  2  00 rt, 01 rd, 11 $31
- pcSrc  out  2  00 PC+4, 01 branch target, 10 jump imm26, 11 register (jr)
- state  out  3  FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4
- illegal  out  1  one-cycle pulse, unsupported instruction
- memTimeout  out  1  one-cycle pulse, MEM access abandoned
- retired  out  CNT_W  completed-instruction count

## Operation
- Supported: addu (funct 100001), subu (100011), jr (001000), ori 001101, lw 100011, sw 101011, beq 000100, lui 001111, jal 000011. Anything else is illegal.
- Outputs are combinational from state plus a class register latched at the end of DECODE. Exception: pcWE in EXEC for beq, which equals zero.
- Unlisted outputs are 0 in every state.
- FETCH: irWE=1, pcWE=1, pcSrc=00. Next state DECODE.
- DECODE: no strobes. Latch class.
  - illegal: illegal=1, next FETCH.
  - jal: next WB.
  - else: next EXEC.
- EXEC: aluCtrl/aluSrc/usExt per class.
  - addu 000/0/0; subu 001/0/0; ori 011/1/1; lui 100/1/1; lw, sw 000/1/0; beq 001/0/0.
  - beq: pcWE=zero, pcSrc=01, next FETCH.
  - jr: pcWE=1, pcSrc=11, next FETCH.
  - lw, sw: next MEM.
  - Others: next WB.
- MEM: aluCtrl/aluSrc held as in EXEC. dmRE=1 for lw, dmWE=1 for sw, held every MEM cycle.
  - memReady=1 (or MEM_WAIT_EN=0): lw goes to WB, sw goes to FETCH.
- WB: regWE=1.
  - addu/subu: regDataCtrl 01, regDesCtrl 01.
  - ori/lui: 01/00.
  - lw: 00/00.
  - jal: 11/11, plus pcWE=1, pcSrc=10.
  - Next FETCH.
- retired increments by 1 on the final cycle of each instruction: WB exit, beq/jr EXEC exit, sw MEM exit. It wraps at 2^CNT_W. It does not increment for illegal or timeout.

## Timing
- Reset (rstN=0, async): state=FETCH, class cleared, wait counter 0, retired 0.
- While rstN=0 every strobe, illegal and memTimeout is forced 0 (combinational gating). The first FETCH completes on the first rising edge with rstN=1.
- Latency in cycles: beq/jr/jal 3; addu/subu/ori/lui 4; sw 4+w; lw 5+w. w is the number of extra MEM cycles, 0..MEM_TIMEOUT-1. Illegal takes 2.
- Wait counter:
  - Cleared on MEM entry.
  - Increments each MEM cycle with memReady=0.
  - If it equals MEM_TIMEOUT-1 and memReady=0: memTimeout=1 that cycle, next FETCH, no WB, no retire.
- memReady=1 on the timeout cycle counts as success; timeout is not asserted.
- memReady outside MEM is ignored.
- Reset asserted mid-MEM: strobes drop immediately, no write-back, retired is not incremented.

## Test plan
- Reset, then addu with rstN released → state 0,1,2,4,0; regWE=1 only in WB with regDataCtrl=01, regDesCtrl=01; retired 0→1.
- lw with MEM_TIMEOUT=16 and memReady high on the 3rd MEM cycle → dmRE high for exactly 3 cycles, then WB with regDataCtrl=00; total 7 cycles.
- sw with MEM_TIMEOUT=4 and memReady held 0 → dmWE high for 4 cycles, memTimeout pulses on the 4th, next state FETCH, retired unchanged.
- beq with zero=0, then beq with zero=1 → pcWE low, then high with pcSrc=01 in EXEC; each takes 3 cycles; retired +2.
- opCode 111111 → illegal pulses in DECODE, no regWE/dmWE, back to FETCH after 2 cycles; jal → WB with regDesCtrl=11, regDataCtrl=11, pcSrc=10, pcWE=1.
- rstN low for one cycle during lw MEM wait → dmRE falls immediately, state=0, retired=0, no regWE afterwards.
